wconv_fifo: RTL and testbench

Single-clock, parametrised width-converting FIFO. It packs a narrow input stream, by default 1 bit per write, into wide output words, by default 8 bits, and buffers those words for the downstream readout/USB path. It is the single-clock, generalised successor to the fixed 1-bit-in / 8-bit-out FIFO. It adds configurable width, ratio and depth, MSB/LSB-first packing, a word count, sticky error flags and an optional partial-word flush.

---
 rtl/wconv_fifo_pkg.sv | 25 ++
 rtl/wconv_fifo_if.sv | 35 +++
 rtl/wconv_fifo_packer.sv | 85 ++++++++
 rtl/wconv_fifo.sv | 125 ++++++++++++
 tb/tb_wconv_fifo.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wconv_fifo_pkg.sv
// Shared types and width helpers for the width-converting FIFO.
package wconv_fifo_pkg;

  typedef enum logic {
    PACK_LSB_FIRST = 1'b0,
    PACK_MSB_FIRST = 1'b1
  } pack_order_e;

  function automatic int out_w(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_w(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/wconv_fifo_if.sv
// Handshake/data bundle of wconv_fifo; master drives the strobes, slave is the FIFO.
interface wconv_fifo_if
  import wconv_fifo_pkg::*;
#(
  parameter int IN_W  = 1,
  parameter int RATIO = 8,
  parameter int DEPTH = 128
);
  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int LVL_W = lvl_w(RATIO);

  logic [IN_W-1:0]  din;
  logic             wr_en;
  logic             flush;
  logic             rd_en;
  logic [OUT_W-1:0] dout;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] word_count;
  logic [LVL_W-1:0] pack_level;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, flush, rd_en,
    input  dout, full, empty, word_count, pack_level, overflow, underflow
  );

  modport slave (
    input  din, wr_en, flush, rd_en,
    output dout, full, empty, word_count, pack_level, overflow, underflow
  );

endinterface

// File: rtl/wconv_fifo_packer.sv
// Chunk packer: shift register, chunk counter, write-accept rule, word strobe
// and zero-padded partial-word commit.
module wconv_packer
  import wconv_fifo_pkg::*;
#(
  parameter int IN_W      = 1,
  parameter int RATIO     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [IN_W-1:0]                din,
  input  logic                           wr_en,
  input  logic                           flush,
  input  logic                           full,
  output logic [lvl_w(RATIO)-1:0]        level,
  output logic [out_w(IN_W, RATIO)-1:0]  word,
  output logic                           push,
  output logic                           drop
);
  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int LVL_W = lvl_w(RATIO);
  localparam int SH_W  = $clog2(OUT_W + 1);
  localparam logic [LVL_W-1:0] LAST = LVL_W'(RATIO - 1);
  localparam pack_order_e ORDER = (MSB_FIRST != 0) ? PACK_MSB_FIRST : PACK_LSB_FIRST;

  logic [OUT_W-1:0] sr_r;
  logic [LVL_W-1:0] level_r;
  logic [OUT_W-1:0] shifted_s;
  logic [OUT_W-1:0] src_s;
  logic [OUT_W-1:0] padded_s;
  logic [LVL_W:0]   eff_level_s;
  logic [SH_W-1:0]  pad_s;
  logic             wr_acc_s;
  logic             completes_s;
  logic             partial_s;
  logic             flush_commit_s;
  logic             flush_drop_s;

  // Accept decision, flush decision and the word presented to storage
  always_comb begin
    wr_acc_s       = wr_en && !(full && (level_r == LAST));
    completes_s    = wr_acc_s && (level_r == LAST);
    eff_level_s    = {1'b0, level_r} + {{LVL_W{1'b0}}, wr_acc_s};
    partial_s      = (eff_level_s != {(LVL_W+1){1'b0}}) && !completes_s;
    flush_commit_s = flush && partial_s && !full;
    flush_drop_s   = flush && partial_s && full;
    if (ORDER == PACK_MSB_FIRST) begin
      shifted_s = {sr_r[OUT_W-IN_W-1:0], din};
    end else begin
      shifted_s = {din, sr_r[OUT_W-1:IN_W]};
    end
    src_s = wr_acc_s ? shifted_s : sr_r;
    // Shifting the held chunks to their final slots also pushes stale bits out
    pad_s = SH_W'((RATIO - int'(eff_level_s)) * IN_W);
    if (ORDER == PACK_MSB_FIRST) begin
      padded_s = src_s << pad_s;
    end else begin
      padded_s = src_s >> pad_s;
    end
    word = completes_s ? shifted_s : padded_s;
    push = completes_s || flush_commit_s;
    drop = (wr_en && !wr_acc_s) || flush_drop_s;
  end

  // Shift register and chunk counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_r    <= {OUT_W{1'b0}};
      level_r <= {LVL_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        sr_r <= shifted_s;
      end
      if (completes_s || flush_commit_s) begin
        level_r <= {LVL_W{1'b0}};
      end else if (wr_acc_s) begin
        level_r <= level_r + LVL_W'(1'b1);
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/wconv_fifo.sv
// Width-converting FIFO top: packer plus word storage, pointers and flags.
// Partial-word flush is compiled in when WCONV_FIFO_FLUSH_EN is defined.
module wconv_fifo
  import wconv_fifo_pkg::*;
#(
  parameter int IN_W      = 1,
  parameter int RATIO     = 8,
  parameter int DEPTH     = 128,
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  wconv_fifo_if.slave bus
);
  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int LVL_W = lvl_w(RATIO);

  logic [OUT_W-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   wr_ptr_nxt_s;
  logic [PTR_W:0]   rd_ptr_nxt_s;
  logic [OUT_W-1:0] dout_r;
  logic [OUT_W-1:0] word_s;
  logic [CNT_W-1:0] count_r;
  logic [LVL_W-1:0] level_s;
  logic             full_r;
  logic             empty_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             full_nxt_s;
  logic             empty_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic             flush_en_s;

`ifdef WCONV_FIFO_FLUSH_EN
  assign flush_en_s = bus.flush;
`else
  assign flush_en_s = bus.flush & 1'b0;
`endif

  wconv_packer #(
    .IN_W      (IN_W),
    .RATIO     (RATIO),
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.din),
    .wr_en (bus.wr_en),
    .flush (flush_en_s),
    .full  (full_r),
    .level (level_s),
    .word  (word_s),
    .push  (push_s),
    .drop  (drop_s)
  );

  // Next pointers; the packer never pushes while full, so no guard is needed here
  always_comb begin
    pop_s = bus.rd_en && !empty_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + (PTR_W+1)'(1'b1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + (PTR_W+1)'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[PTR_W] != rd_ptr_nxt_s[PTR_W]) &&
                  (wr_ptr_nxt_s[PTR_W-1:0] == rd_ptr_nxt_s[PTR_W-1:0]);
  end

  // Word storage
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= word_s;
    end
  end

  // Pointers, status flags and registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {(PTR_W+1){1'b0}};
      rd_ptr_r    <= {(PTR_W+1){1'b0}};
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      count_r     <= {CNT_W{1'b0}};
      dout_r      <= {OUT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
      count_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      if (pop_s) begin
        dout_r <= mem_r[rd_ptr_r[PTR_W-1:0]];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.rd_en && empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_r;
  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.word_count = count_r;
  assign bus.pack_level = level_s;
  assign bus.overflow   = overflow_r;
  assign bus.underflow  = underflow_r;

endmodule

// File: tb/tb_wconv_fifo.sv
// Self-checking bench: an MSB-first and an LSB-first FIFO (DEPTH=4) share one stimulus stream.
module tb_wconv_fifo;
  localparam int IN_W  = 1;
  localparam int RATIO = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_q [$];
  vec_t vecs [5];

  always #5 clk = ~clk;

  wconv_fifo_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus_m ();
  wconv_fifo_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus_l ();

  assign bus_l.din   = bus_m.din;
  assign bus_l.wr_en = bus_m.wr_en;
  assign bus_l.flush = bus_m.flush;
  assign bus_l.rd_en = bus_m.rd_en;

  wconv_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  wconv_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b, input logic rd);
    bus_m.din   = b;
    bus_m.wr_en = 1'b1;
    bus_m.rd_en = rd;
    step();
    bus_m.wr_en = 1'b0;
    bus_m.rd_en = 1'b0;
  endtask

  task automatic chk_pop(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", name, bus_m.dout);
    end else begin
      e = exp_q.pop_front();
      chk(name, int'(bus_m.dout), int'(e));
    end
  endtask

  // Chunks go out MSB of w first; optionally pop in the cycle the word completes.
  task automatic write_word(input logic [7:0] w, input logic [7:0] exp, input logic pop_last);
    for (int i = 7; i >= 1; i--) begin
      put_bit(w[i], 1'b0);
    end
    put_bit(w[0], pop_last);
    exp_q.push_back(exp);
    if (pop_last) begin
      chk_pop("pop_with_push");
    end
  endtask

  task automatic read_word(input string name);
    bus_m.rd_en = 1'b1;
    step();
    bus_m.rd_en = 1'b0;
    chk_pop(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hB2, 8'hB2, 8'h4D};
    vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{8'h01, 8'h01, 8'h80};
    vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[4] = '{8'h96, 8'h96, 8'h69};

    rst_n       = 1'b0;
    bus_m.din   = 1'b0;
    bus_m.wr_en = 1'b0;
    bus_m.flush = 1'b0;
    bus_m.rd_en = 1'b0;
    step();
    step();
    chk("rst_empty", int'(bus_m.empty), 1);
    chk("rst_full", int'(bus_m.full), 0);
    chk("rst_count", int'(bus_m.word_count), 0);
    chk("rst_level", int'(bus_m.pack_level), 0);
    chk("rst_dout", int'(bus_m.dout), 0);
    chk("rst_ovf", int'(bus_m.overflow), 0);
    chk("rst_unf", int'(bus_m.underflow), 0);

    // Read while empty
    rst_n       = 1'b1;
    bus_m.rd_en = 1'b1;
    step();
    bus_m.rd_en = 1'b0;
    chk("unf_set", int'(bus_m.underflow), 1);
    chk("unf_dout_held", int'(bus_m.dout), 0);
    chk("unf_empty", int'(bus_m.empty), 1);

    // Table of single words, both packing orders
    for (int k = 0; k < 5; k++) begin
      write_word(vecs[k].bits, vecs[k].exp_msb, 1'b0);
      chk("word_empty_low", int'(bus_m.empty), 0);
      chk("word_count_1", int'(bus_m.word_count), 1);
      read_word("msb_dout");
      chk("lsb_dout", int'(bus_l.dout), int'(vecs[k].exp_lsb));
      chk("read_empty", int'(bus_m.empty), 1);
    end
    chk("unf_sticky", int'(bus_m.underflow), 1);
    chk("no_ovf", int'(bus_m.overflow), 0);

    // Fill storage, then fill the packer behind it
    for (int k = 0; k < 4; k++) begin
      write_word(8'hFF, 8'hFF, 1'b0);
    end
    chk("fill_full", int'(bus_m.full), 1);
    chk("fill_count", int'(bus_m.word_count), 4);
    for (int k = 0; k < 7; k++) begin
      put_bit(1'b1, 1'b0);
    end
    chk("partial_level", int'(bus_m.pack_level), 7);
    chk("partial_no_ovf", int'(bus_m.overflow), 0);
    put_bit(1'b1, 1'b0);
    chk("reject_ovf", int'(bus_m.overflow), 1);
    chk("reject_level", int'(bus_m.pack_level), 7);
    chk("reject_count", int'(bus_m.word_count), 4);
    // Completing write alongside a pop at full is still rejected
    put_bit(1'b1, 1'b1);
    chk_pop("pop_at_full");
    chk("pop_at_full_count", int'(bus_m.word_count), 3);
    chk("pop_at_full_level", int'(bus_m.pack_level), 7);
    chk("pop_at_full_full", int'(bus_m.full), 0);
    put_bit(1'b1, 1'b0);
    exp_q.push_back(8'hFF);
    chk("refill_count", int'(bus_m.word_count), 4);
    chk("refill_level", int'(bus_m.pack_level), 0);
    for (int k = 0; k < 4; k++) begin
      read_word("drain_full");
    end
    chk("drain_empty", int'(bus_m.empty), 1);
    do_reset();
    chk("reset_clears_ovf", int'(bus_m.overflow), 0);
    chk("reset_clears_unf", int'(bus_m.underflow), 0);

    // Partial-word flush
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    bus_m.flush = 1'b1;
    step();
    bus_m.flush = 1'b0;
`ifdef WCONV_FIFO_FLUSH_EN
    chk("flush_level", int'(bus_m.pack_level), 0);
    chk("flush_count", int'(bus_m.word_count), 1);
    exp_q.push_back(8'hE0);
    read_word("flush_msb");
    chk("flush_lsb", int'(bus_l.dout), 8'h07);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    bus_m.din   = 1'b1;
    bus_m.wr_en = 1'b1;
    bus_m.flush = 1'b1;
    step();
    bus_m.wr_en = 1'b0;
    bus_m.flush = 1'b0;
    chk("flush_wr_level", int'(bus_m.pack_level), 0);
    chk("flush_wr_count", int'(bus_m.word_count), 1);
    exp_q.push_back(8'hA0);
    read_word("flush_wr_msb");
    chk("flush_wr_lsb", int'(bus_l.dout), 8'h05);
    bus_m.flush = 1'b1;
    step();
    bus_m.flush = 1'b0;
    chk("flush_noop_empty", int'(bus_m.empty), 1);
    chk("flush_noop_level", int'(bus_m.pack_level), 0);
`else
    chk("noflush_empty", int'(bus_m.empty), 1);
    chk("noflush_level", int'(bus_m.pack_level), 3);
    chk("noflush_count", int'(bus_m.word_count), 0);
`endif
    do_reset();

    // Interleaved push/pop across pointer wrap
    for (int w = 0; w < 3; w++) begin
      write_word(8'(w), 8'(w), 1'b0);
    end
    chk("wrap_prefill", int'(bus_m.word_count), 3);
    for (int w = 3; w < 10; w++) begin
      write_word(8'(w), 8'(w), 1'b1);
      chk("wrap_count", int'(bus_m.word_count), 3);
    end
    for (int k = 0; k < 3; k++) begin
      read_word("wrap_drain");
    end
    chk("wrap_ovf", int'(bus_m.overflow), 0);
    chk("wrap_unf", int'(bus_m.underflow), 0);
    chk("wrap_empty", int'(bus_m.empty), 1);

    // Reset mid-word with stored words and strobes asserted
    write_word(8'h11, 8'h11, 1'b0);
    write_word(8'h22, 8'h22, 1'b0);
    for (int k = 0; k < 5; k++) begin
      put_bit(1'b1, 1'b0);
    end
    rst_n       = 1'b0;
    bus_m.din   = 1'b1;
    bus_m.wr_en = 1'b1;
    bus_m.rd_en = 1'b1;
    step();
    bus_m.wr_en = 1'b0;
    bus_m.rd_en = 1'b0;
    rst_n       = 1'b1;
    exp_q.delete();
    chk("midrst_empty", int'(bus_m.empty), 1);
    chk("midrst_count", int'(bus_m.word_count), 0);
    chk("midrst_level", int'(bus_m.pack_level), 0);
    chk("midrst_dout", int'(bus_m.dout), 0);
    chk("midrst_unf", int'(bus_m.underflow), 0);
    write_word(8'h5A, 8'h5A, 1'b0);
    read_word("post_rst_msb");
    chk("post_rst_lsb", int'(bus_l.dout), 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
